// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizing for the scrubbing register
//               file (controller state encoding, default WIDTH/DEPTH/NRD).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Controller state: normal operation or array-wide clear in progress
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  localparam int c_def_width = 32;
  localparam int c_def_depth = 32;
  localparam int c_def_nrd   = 2;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rdport
// Description : One combinational read port of the register file. Selects an
//               entry from the flattened array, forces zero while the array
//               is being scrubbed and, when REGFILE_BYPASS_EN is defined,
//               forwards same-cycle write data to a matching address.
// Macro       : REGFILE_BYPASS_EN (optional write-to-read bypass)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int DEPTH = c_def_depth
) (
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DEPTH*WIDTH-1:0]   i_mem,
  input  logic                     i_busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
`endif
  output logic [WIDTH-1:0]         o_data
);

  // Address mux; slot 0 of the flattened array is tied to zero by the top
  always_comb begin
    o_data = i_mem[i_addr*WIDTH +: WIDTH];
`ifdef REGFILE_BYPASS_EN
    // i_wr_en already excludes address 0 and the scrub window
    if (i_wr_en && (i_wr_addr == i_addr)) begin
      o_data = i_wr_data;
    end
`endif
    if (i_busy) begin
      o_data = '0;
    end
  end

endmodule : regfile_rdport
`default_nettype wire

// File: rtl/regfile_scrub.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scrub
// Description : Multi-read-port register file with a hardwired-zero entry 0
//               and a background scrub controller that clears entries
//               1..DEPTH-1, one per cycle, after reset or on a Clr request.
//               Writes arriving during a scrub are dropped and flagged.
// Macro       : REGFILE_BYPASS_EN (read ports forward same-cycle write data)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scrub
  import regfile_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int DEPTH = c_def_depth,
  parameter int NRD   = c_def_nrd
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Clr,
  input  logic                         RegWr,
  input  logic [$clog2(DEPTH)-1:0]     WrReg,
  input  logic [WIDTH-1:0]             WrData,
  input  logic [NRD*$clog2(DEPTH)-1:0] RdReg,
  output logic [NRD*WIDTH-1:0]         RdData,
  output logic                         Busy,
  output logic                         WrErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_first = AW'(1);
  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_cnt;
  logic [AW-1:0]       w_cnt_nxt;
  logic                r_wrerr;
  logic                w_wrerr_nxt;
  logic                w_busy;
  logic                w_wr_en;
  logic [WIDTH-1:0]    r_mem [1:DEPTH-1];
  logic [DEPTH*WIDTH-1:0] w_mem_flat;

  assign w_busy  = (r_state == SCRUB);
  assign w_wr_en = !w_busy && RegWr && (WrReg != '0);
  assign Busy    = w_busy;
  assign WrErr   = r_wrerr;

  // Controller state, scrub pointer and dropped-write flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCRUB;
      r_cnt   <= c_first;
      r_wrerr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrerr <= w_wrerr_nxt;
    end
  end

  // Next-state logic; the pointer parks on the last entry instead of wrapping
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wrerr_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Clr) begin
          w_state_nxt = SCRUB;
          w_cnt_nxt   = c_first;
        end
      end
      SCRUB: begin
        w_wrerr_nxt = RegWr && (WrReg != '0);
        if (r_cnt == c_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage update: scrub clears one entry per cycle, otherwise user writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_busy) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr_en) begin
        r_mem[WrReg] <= WrData;
      end
    end
  end

  // Flatten the array for the read ports; entry 0 is a constant zero
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    if (i == 0) begin : g_zero
      assign w_mem_flat[i*WIDTH +: WIDTH] = '0;
    end else begin : g_entry
      assign w_mem_flat[i*WIDTH +: WIDTH] = r_mem[i];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_rdport (
      .i_addr    (RdReg[k*AW +: AW]),
      .i_mem     (w_mem_flat),
      .i_busy    (w_busy),
`ifdef REGFILE_BYPASS_EN
      .i_wr_en   (w_wr_en),
      .i_wr_addr (WrReg),
      .i_wr_data (WrData),
`endif
      .o_data    (RdData[k*WIDTH +: WIDTH])
    );
  end

endmodule : regfile_scrub
`default_nettype wire

// File: tb/tb_regfile_scrub.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scrub
// Description : Self-checking bench for regfile_scrub. A default-sized
//               instance (32x32, 2 ports) is tracked cycle by cycle against an
//               abstract model; a small instance (8x16, 4 ports) gets
//               directed checks.
// Macro       : REGFILE_BYPASS_EN (selects expected same-cycle read result)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scrub;

  logic        clk;
  logic        reset, Clr, RegWr;
  logic [4:0]  WrReg;
  logic [31:0] WrData;
  logic [9:0]  RdReg;
  logic [63:0] RdData;
  logic        Busy, WrErr;

  logic        s_reset, s_clr, s_regwr;
  logic [2:0]  s_wrreg;
  logic [15:0] s_wrdata;
  logic [11:0] s_rdreg;
  logic [63:0] s_rddata;
  logic        s_busy, s_wrerr;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Model: scrub is observable only as "reads are zero, writes dropped for
  // DEPTH-1 cycles, then everything reads zero", so clear at scrub start.
  logic [31:0] m_mem [32];
  int          m_busy = 0;
  logic        m_wrerr = 1'b0;

  regfile_scrub u_dut (
    .clk(clk), .reset(reset), .Clr(Clr), .RegWr(RegWr), .WrReg(WrReg),
    .WrData(WrData), .RdReg(RdReg), .RdData(RdData), .Busy(Busy), .WrErr(WrErr)
  );

  regfile_scrub #(.WIDTH(16), .DEPTH(8), .NRD(4)) u_small (
    .clk(clk), .reset(s_reset), .Clr(s_clr), .RegWr(s_regwr), .WrReg(s_wrreg),
    .WrData(s_wrdata), .RdReg(s_rdreg), .RdData(s_rddata), .Busy(s_busy),
    .WrErr(s_wrerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input int k);
    logic [4:0] a;
    a = RdReg[k*5 +: 5];
    if (m_busy > 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWr && (WrReg == a)) return WrData;
`endif
    return m_mem[a];
  endfunction

  // Model update on every rising edge
  always @(posedge clk) begin
    if (reset) begin
      m_busy  = 31;
      m_wrerr = 1'b0;
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    end else if (m_busy > 0) begin
      m_wrerr = RegWr && (WrReg != 5'd0);
      m_busy  = m_busy - 1;
    end else begin
      m_wrerr = 1'b0;
      if (RegWr && (WrReg != 5'd0)) m_mem[WrReg] = WrData;
      if (Clr) begin
        m_busy = 31;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, Busy}, {63'd0, (m_busy > 0)});
      chk("wrerr", {63'd0, WrErr}, {63'd0, m_wrerr});
      for (int k = 0; k < 2; k++)
        chk($sformatf("rd%0d", k), {32'd0, RdData[k*32 +: 32]}, {32'd0, exp_rd(k)});
    end
  end

  initial begin
    int n;
    reset = 1'b1; Clr = 1'b0; RegWr = 1'b0; WrReg = '0; WrData = '0;
    RdReg = {5'd3, 5'd1};
    s_reset = 1'b1; s_clr = 1'b0; s_regwr = 1'b0; s_wrreg = '0; s_wrdata = '0;
    s_rdreg = '0;

    // Reset for two cycles, then measure the scrub length
    tick();
    chk_en = 1'b1;
    chk("busy_in_reset", {63'd0, Busy}, 64'd1);
    tick();
    reset = 1'b0;
    n = 0;
    while (Busy && n < 100) begin tick(); n++; end
    chk("scrub_len_reset", n, 31);

    // Write 0xDEADBEEF to entry 5, read on both ports
    RegWr = 1'b1; WrReg = 5'd5; WrData = 32'hDEADBEEF;
    tick();
    RegWr = 1'b0; RdReg = {5'd5, 5'd5};
    #1;
    chk("rd5_p0", {32'd0, RdData[31:0]},  64'hDEADBEEF);
    chk("rd5_p1", {32'd0, RdData[63:32]}, 64'hDEADBEEF);

    // Write to entry 0 is discarded silently
    RegWr = 1'b1; WrReg = 5'd0; WrData = 32'h1234;
    tick();
    RegWr = 1'b0; RdReg = {5'd5, 5'd0};
    #1;
    chk("rd0_zero", {32'd0, RdData[31:0]}, 64'h0);
    chk("wr0_no_err", {63'd0, WrErr}, 64'd0);

    // Same-cycle write/read of entry 3
    RegWr = 1'b1; WrReg = 5'd3; WrData = 32'h11111111;
    tick();
    WrData = 32'hA5A5A5A5; RdReg = {5'd3, 5'd5};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_p1", {32'd0, RdData[63:32]}, 64'hA5A5A5A5);
`else
    chk("nobypass_p1", {32'd0, RdData[63:32]}, 64'h11111111);
`endif
    tick();
    RegWr = 1'b0;
    #1;
    chk("rd3_after", {32'd0, RdData[63:32]}, 64'hA5A5A5A5);

    // Write during scrub is dropped and flagged; repeated Clr ignored
    RegWr = 1'b1; WrReg = 5'd7; WrData = 32'h07070707;
    tick();
    RegWr = 1'b0; Clr = 1'b1;
    tick();
    Clr = 1'b0;
    chk("busy_after_clr", {63'd0, Busy}, 64'd1);
    n = 0;
    RegWr = 1'b1; WrReg = 5'd7; WrData = 32'h0BAD0BAD;
    tick(); n++;
    RegWr = 1'b0;
    chk("wrerr_pulse", {63'd0, WrErr}, 64'd1);
    tick(); n++;
    chk("wrerr_single", {63'd0, WrErr}, 64'd0);
    Clr = 1'b1;
    tick(); n++;
    Clr = 1'b0;
    while (Busy && n < 100) begin tick(); n++; end
    chk("scrub_len_clr", n, 31);
    RdReg = {5'd7, 5'd5};
    #1;
    chk("rd7_cleared", {32'd0, RdData[63:32]}, 64'h0);
    chk("rd5_cleared", {32'd0, RdData[31:0]},  64'h0);

    // Clr and RegWr together: write lands, then is scrubbed
    Clr = 1'b1; RegWr = 1'b1; WrReg = 5'd9; WrData = 32'h99999999;
    tick();
    Clr = 1'b0; RegWr = 1'b0;
    chk("clr_wr_busy", {63'd0, Busy}, 64'd1);
    n = 0;
    while (Busy && n < 100) begin tick(); n++; end
    chk("scrub_len_clrwr", n, 31);
    RdReg = {5'd9, 5'd9};
    #1;
    chk("rd9_cleared", {32'd0, RdData[31:0]}, 64'h0);

    // Fill, scrub, Clr mid-scrub, reset mid-scrub
    for (int i = 1; i < 32; i++) begin
      RegWr = 1'b1; WrReg = 5'(i); WrData = i * 32'h01010101;
      tick();
    end
    RegWr = 1'b0; RdReg = {5'd31, 5'd1};
    #1;
    chk("fill_p0", {32'd0, RdData[31:0]},  64'h01010101);
    chk("fill_p1", {32'd0, RdData[63:32]}, 64'h1F1F1F1F);
    for (int c = 1; c <= 20; c++) begin
      Clr   = (c == 1) || (c == 10);
      reset = (c == 20);
      tick();
    end
    Clr = 1'b0; reset = 1'b0;
    n = 0;
    while (Busy && n < 100) begin tick(); n++; end
    chk("scrub_len_rst_mid", n, 31);
    for (int a = 0; a < 32; a++) begin
      RdReg = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("zero_p0_%0d", a), {32'd0, RdData[31:0]},  64'h0);
      chk($sformatf("zero_p1_%0d", a), {32'd0, RdData[63:32]}, 64'h0);
    end

    // Small configuration: 8 entries x 16 bits, 4 read ports
    s_reset = 1'b0;
    n = 0;
    while (s_busy && n < 100) begin tick(); n++; end
    chk("small_scrub_len", n, 7);
    for (int i = 1; i < 8; i++) begin
      s_regwr = 1'b1; s_wrreg = 3'(i); s_wrdata = 16'h1000 + 16'(i);
      tick();
    end
    s_regwr = 1'b0;
    s_rdreg = {3'd0, 3'd2, 3'd5, 3'd7};
    #1;
    chk("small_pat1", s_rddata, {16'h0000, 16'h1002, 16'h1005, 16'h1007});
    s_rdreg = {3'd4, 3'd6, 3'd3, 3'd1};
    #1;
    chk("small_pat2", s_rddata, {16'h1004, 16'h1006, 16'h1003, 16'h1001});
    chk("small_wrerr", {63'd0, s_wrerr}, 64'd0);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    n = 0;
    while (s_busy && n < 100) begin tick(); n++; end
    chk("small_scrub_clr", n, 7);
    #1;
    chk("small_cleared", s_rddata, 64'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_scrub
`default_nettype wire
